// File: rtl/sim_seed_sequencer.sv
// Batch sequencer for the SIM_toggle datapath: per seed it fetches the initial state,
// cycles the datapath reset, loads the inhibitor, starts a run and reports one result record.
module sim_seed_sequencer #(
   parameter int STATE     = 64,
   parameter int LOG_RULES = 8,
   parameter int SEED_AW   = 8,
   parameter int ITER_W    = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 go,
   input  logic                 abort,
   input  logic [SEED_AW-1:0]   num_seeds,
   input  logic [ITER_W-1:0]    max_iter,
   input  logic [LOG_RULES-1:0] inhibitor,
   input  logic                 early_stop,
   output logic                 busy,
   output logic                 done,
   output logic                 seed_rd,
   output logic [SEED_AW-1:0]   seed_addr,
   input  logic [STATE-1:0]     seed_data,
   output logic                 dp_rst,
   output logic                 start,
   output logic                 ld_inhibitor,
   output logic [LOG_RULES-1:0] sel_inhibitor,
   output logic [STATE-1:0]     initial_state,
   input  logic [ITER_W-1:0]    iteration_number,
   input  logic                 steady_state,
   input  logic [STATE-1:0]     network_state,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [SEED_AW-1:0]   res_seed,
   output logic [STATE-1:0]     res_state,
   output logic [ITER_W-1:0]    res_iters,
   output logic                 res_steady
);

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_LATCH, S_RST2, S_LDINH, S_GAP, S_START, S_RUN, S_REPORT, S_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [SEED_AW-1:0]   num_q, num_d;
   logic [ITER_W-1:0]    max_iter_q, max_iter_d;
   logic [LOG_RULES-1:0] inh_q, inh_d;
   logic                 early_q, early_d;
   logic [SEED_AW-1:0]   idx_q, idx_d;
   logic [SEED_AW-1:0]   idx_inc;
   logic [STATE-1:0]     init_q, init_d;
   logic                 res_valid_q, res_valid_d;
   logic [SEED_AW-1:0]   res_seed_q, res_seed_d;
   logic [STATE-1:0]     res_state_q, res_state_d;
   logic [ITER_W-1:0]    res_iters_q, res_iters_d;
   logic                 res_steady_q, res_steady_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 seed_rd_q, seed_rd_d;
   logic                 dp_rst_q, dp_rst_d;
   logic                 start_q, start_d;
   logic                 ld_inh_q, ld_inh_d;

   assign idx_inc = idx_q + SEED_AW'(1);

   always_comb begin
      state_d      = state_q;
      num_d        = num_q;
      max_iter_d   = max_iter_q;
      inh_d        = inh_q;
      early_d      = early_q;
      idx_d        = idx_q;
      init_d       = init_q;
      res_seed_d   = res_seed_q;
      res_state_d  = res_state_q;
      res_iters_d  = res_iters_q;
      res_steady_d = res_steady_q;

      case (state_q)
         S_IDLE: begin
            if (go && !abort) begin
               num_d      = num_seeds;
               max_iter_d = max_iter;
               inh_d      = inhibitor;
               early_d    = early_stop;
               idx_d      = '0;
               state_d    = (num_seeds == '0) ? S_DONE : S_FETCH;
            end
         end
         S_FETCH: state_d = S_LATCH;
         S_LATCH: begin
            init_d  = seed_data;
            state_d = S_RST2;
         end
         S_RST2:  state_d = S_LDINH;
         S_LDINH: state_d = S_GAP;
         S_GAP:   state_d = S_START;
         S_START: state_d = S_RUN;
         S_RUN: begin
            if ((iteration_number >= max_iter_q) || (early_q && steady_state)) begin
               res_seed_d   = idx_q;
               res_state_d  = network_state;
               res_iters_d  = iteration_number;
               res_steady_d = steady_state;
               state_d      = S_REPORT;
            end
         end
         S_REPORT: begin
            if (res_ready) begin
               idx_d   = idx_inc;
               state_d = (idx_inc == num_q) ? S_DONE : S_FETCH;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (abort) state_d = S_IDLE;

      // Moore outputs are decoded from the next state so each flop tracks its state exactly
      busy_d      = (state_d != S_IDLE);
      done_d      = (state_d == S_DONE);
      seed_rd_d   = (state_d == S_FETCH);
      start_d     = (state_d == S_START);
      ld_inh_d    = (state_d == S_LDINH);
      res_valid_d = (state_d == S_REPORT);
      dp_rst_d    = (state_d == S_LDINH) || (state_d == S_GAP) || (state_d == S_START) ||
                    (state_d == S_RUN) || (state_d == S_REPORT);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         num_q        <= '0;
         max_iter_q   <= '0;
         inh_q        <= '0;
         early_q      <= 1'b0;
         idx_q        <= '0;
         init_q       <= '0;
         res_valid_q  <= 1'b0;
         res_seed_q   <= '0;
         res_state_q  <= '0;
         res_iters_q  <= '0;
         res_steady_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         seed_rd_q    <= 1'b0;
         dp_rst_q     <= 1'b0;
         start_q      <= 1'b0;
         ld_inh_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         num_q        <= num_d;
         max_iter_q   <= max_iter_d;
         inh_q        <= inh_d;
         early_q      <= early_d;
         idx_q        <= idx_d;
         init_q       <= init_d;
         res_valid_q  <= res_valid_d;
         res_seed_q   <= res_seed_d;
         res_state_q  <= res_state_d;
         res_iters_q  <= res_iters_d;
         res_steady_q <= res_steady_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         seed_rd_q    <= seed_rd_d;
         dp_rst_q     <= dp_rst_d;
         start_q      <= start_d;
         ld_inh_q     <= ld_inh_d;
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign seed_rd       = seed_rd_q;
   assign seed_addr     = idx_q;
   assign dp_rst        = dp_rst_q;
   assign start         = start_q;
   assign ld_inhibitor  = ld_inh_q;
   assign sel_inhibitor = ~inh_q;
   assign initial_state = init_q;
   assign res_valid     = res_valid_q;
   assign res_seed      = res_seed_q;
   assign res_state     = res_state_q;
   assign res_iters     = res_iters_q;
   assign res_steady    = res_steady_q;

endmodule

// File: tb/tb_sim_seed_sequencer.sv
// Directed bench for sim_seed_sequencer with a small behavioural datapath and seed memory.
module tb_sim_seed_sequencer;
   localparam int STATE = 64, LOG_RULES = 8, SEED_AW = 8, ITER_W = 10;

   logic                 clk = 1'b0, rst = 1'b0;
   logic                 go = 1'b0, abort = 1'b0, early_stop = 1'b0, res_ready = 1'b0;
   logic [SEED_AW-1:0]   num_seeds = '0;
   logic [ITER_W-1:0]    max_iter = '0;
   logic [LOG_RULES-1:0] inhibitor = '0;
   logic                 busy, done, seed_rd, dp_rst, start, ld_inhibitor;
   logic                 steady_state, res_valid, res_steady;
   logic [SEED_AW-1:0]   seed_addr, res_seed;
   logic [STATE-1:0]     seed_data = '0, initial_state, network_state, res_state;
   logic [LOG_RULES-1:0] sel_inhibitor;
   logic [ITER_W-1:0]    iteration_number, res_iters;

   sim_seed_sequencer #(.STATE(STATE), .LOG_RULES(LOG_RULES), .SEED_AW(SEED_AW), .ITER_W(ITER_W)) dut (
      .clk(clk), .rst(rst), .go(go), .abort(abort), .num_seeds(num_seeds), .max_iter(max_iter),
      .inhibitor(inhibitor), .early_stop(early_stop), .busy(busy), .done(done), .seed_rd(seed_rd),
      .seed_addr(seed_addr), .seed_data(seed_data), .dp_rst(dp_rst), .start(start),
      .ld_inhibitor(ld_inhibitor), .sel_inhibitor(sel_inhibitor), .initial_state(initial_state),
      .iteration_number(iteration_number), .steady_state(steady_state), .network_state(network_state),
      .res_valid(res_valid), .res_ready(res_ready), .res_seed(res_seed), .res_state(res_state),
      .res_iters(res_iters), .res_steady(res_steady)
   );

   always #5 clk = ~clk;

   int cyc = 0, base = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Seed memory: one-cycle read latency
   logic [STATE-1:0] mem [4];
   always @(posedge clk) if (seed_rd) seed_data <= mem[seed_addr[1:0]];

   // Datapath model: iteration k is presented k cycles into RUN; state = seed + iteration
   logic [ITER_W-1:0] dp_iter = '0;
   logic              dp_run = 1'b0;
   int                steady_at = 0;
   always @(posedge clk) begin
      if (!dp_rst) begin
         dp_iter <= '0;
         dp_run  <= 1'b0;
      end else if (start) dp_run <= 1'b1;
      else if (dp_run && dp_iter != '1) dp_iter <= dp_iter + 1'b1;
   end
   assign iteration_number = dp_iter;
   assign steady_state     = dp_run && (steady_at != 0) && (int'(dp_iter) >= steady_at);
   assign network_state    = initial_state + STATE'(dp_iter);

   int n_chk = 0, n_err = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int rel();
      return cyc - base + 1;
   endfunction

   // Called at a negedge; returns at the negedge of cycle 1
   task automatic start_batch(input logic [SEED_AW-1:0] n, input logic [ITER_W-1:0] mi,
                              input logic [LOG_RULES-1:0] inh, input logic es);
      num_seeds = n; max_iter = mi; inhibitor = inh; early_stop = es; go = 1'b1;
      @(negedge clk);
      go   = 1'b0;
      base = cyc;
   endtask

   task automatic wait_valid(input string tag, input int limit);
      for (int i = 0; i < limit && !res_valid; i++) @(negedge clk);
      check_eq(tag, 64'(res_valid), 64'(1));
   endtask

   task automatic wait_done(input string tag, input int limit);
      for (int i = 0; i < limit && !done; i++) @(negedge clk);
      check_eq(tag, 64'(done), 64'(1));
      @(negedge clk);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:1] exp_rd, exp_dprst, exp_ld, exp_start;
      int nrec, cnt;
      mem[0] = 64'h1; mem[1] = 64'h2; mem[2] = 64'h3; mem[3] = 64'h0;

      // Reset values
      repeat (2) @(negedge clk);
      check_eq("rst_busy", 64'(busy), 64'(0));
      check_eq("rst_done", 64'(done), 64'(0));
      check_eq("rst_seed_rd", 64'(seed_rd), 64'(0));
      check_eq("rst_start", 64'(start), 64'(0));
      check_eq("rst_ld_inh", 64'(ld_inhibitor), 64'(0));
      check_eq("rst_res_valid", 64'(res_valid), 64'(0));
      check_eq("rst_dp_rst", 64'(dp_rst), 64'(0));
      check_eq("rst_seed_addr", 64'(seed_addr), 64'(0));
      check_eq("rst_init_state", initial_state, 64'(0));
      check_eq("rst_sel_inh", 64'(sel_inhibitor), 64'hFF);
      check_eq("rst_res_iters", 64'(res_iters), 64'(0));
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Three-seed batch with exact pulse timing for seed 0
      res_ready = 1'b1; steady_at = 2;
      start_batch(8'd3, 10'd5, 8'h05, 1'b0);
      exp_rd = 7'b0000001; exp_dprst = 7'b1111000; exp_ld = 7'b0001000; exp_start = 7'b0100000;
      for (int c = 1; c <= 7; c++) begin
         if (c > 1) @(negedge clk);
         check_eq($sformatf("seed_rd@%0d", c), 64'(seed_rd), 64'(exp_rd[c]));
         check_eq($sformatf("dp_rst@%0d", c), 64'(dp_rst), 64'(exp_dprst[c]));
         check_eq($sformatf("ld_inh@%0d", c), 64'(ld_inhibitor), 64'(exp_ld[c]));
         check_eq($sformatf("start@%0d", c), 64'(start), 64'(exp_start[c]));
         check_eq($sformatf("busy@%0d", c), 64'(busy), 64'(1));
         if (c == 1) begin
            check_eq("sel_inh", 64'(sel_inhibitor), 64'hFA);
            check_eq("seed_addr0", 64'(seed_addr), 64'(0));
         end
         if (c == 3) check_eq("init_state0", initial_state, 64'h1);
      end
      nrec = 0;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         if (res_valid && res_ready) begin
            check_eq($sformatf("rec%0d_seed", nrec), 64'(res_seed), 64'(nrec));
            check_eq($sformatf("rec%0d_iters", nrec), 64'(res_iters), 64'(5));
            check_eq($sformatf("rec%0d_state", nrec), res_state, 64'(nrec + 1 + 5));
            check_eq($sformatf("rec%0d_steady", nrec), 64'(res_steady), 64'(1));
            check_eq($sformatf("rec%0d_cycle", nrec), 64'(rel()), 64'(13 + 13 * nrec));
            nrec++;
         end
      end
      check_eq("batch_done", 64'(done), 64'(1));
      check_eq("batch_done_cycle", 64'(rel()), 64'(40));
      check_eq("batch_records", 64'(nrec), 64'(3));
      @(negedge clk);
      check_eq("batch_busy_low", 64'(busy), 64'(0));
      check_eq("batch_done_pulse", 64'(done), 64'(0));

      // Early stop on steady state; config changes while busy are ignored
      steady_at = 2;
      start_batch(8'd1, 10'd100, 8'h00, 1'b1);
      max_iter = 10'd0; early_stop = 1'b0; num_seeds = 8'd5;
      wait_valid("es_valid", 40);
      check_eq("es_steady", 64'(res_steady), 64'(1));
      check_eq("es_iters", 64'(res_iters), 64'(2));
      check_eq("es_state", res_state, 64'h3);
      check_eq("es_cycle", 64'(rel()), 64'(10));
      wait_done("es_done", 20);
      check_eq("es_idle", 64'(busy), 64'(0));
      steady_at = 0;

      // Empty batch
      start_batch(8'd0, 10'd5, 8'h00, 1'b0);
      cnt = 0;
      check_eq("zero_done", 64'(done), 64'(1));
      check_eq("zero_busy", 64'(busy), 64'(1));
      for (int c = 1; c <= 4; c++) begin
         if (c > 1) @(negedge clk);
         if (seed_rd || start || ld_inhibitor || dp_rst) cnt++;
      end
      check_eq("zero_strobes", 64'(cnt), 64'(0));
      check_eq("zero_busy_after", 64'(busy), 64'(0));

      // Back-pressure in REPORT
      res_ready = 1'b0;
      start_batch(8'd2, 10'd3, 8'h00, 1'b0);
      wait_valid("bp_valid", 40);
      check_eq("bp_seed", 64'(res_seed), 64'(0));
      check_eq("bp_iters", 64'(res_iters), 64'(3));
      check_eq("bp_state", res_state, 64'h4);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check_eq($sformatf("bp_hold_valid%0d", c), 64'(res_valid), 64'(1));
         check_eq($sformatf("bp_hold_state%0d", c), res_state, 64'h4);
         check_eq($sformatf("bp_hold_iters%0d", c), 64'(res_iters), 64'(3));
         check_eq($sformatf("bp_no_fetch%0d", c), 64'(seed_rd), 64'(0));
      end
      res_ready = 1'b1;
      @(negedge clk);
      check_eq("bp_fetch", 64'(seed_rd), 64'(1));
      check_eq("bp_fetch_addr", 64'(seed_addr), 64'(1));
      check_eq("bp_valid_drop", 64'(res_valid), 64'(0));
      wait_valid("bp_valid2", 40);
      check_eq("bp_seed2", 64'(res_seed), 64'(1));
      check_eq("bp_state2", res_state, 64'h5);
      wait_done("bp_done", 20);

      // Abort during RUN, then a fresh batch
      start_batch(8'd3, 10'd50, 8'h00, 1'b0);
      repeat (9) @(negedge clk);
      check_eq("ab_in_run", 64'(dp_rst), 64'(1));
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check_eq("ab_busy", 64'(busy), 64'(0));
      check_eq("ab_dp_rst", 64'(dp_rst), 64'(0));
      check_eq("ab_res_valid", 64'(res_valid), 64'(0));
      cnt = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (done || res_valid || busy) cnt++;
      end
      check_eq("ab_quiet", 64'(cnt), 64'(0));
      start_batch(8'd1, 10'd2, 8'h00, 1'b0);
      wait_valid("ab_restart_valid", 40);
      check_eq("ab_restart_seed", 64'(res_seed), 64'(0));
      check_eq("ab_restart_iters", 64'(res_iters), 64'(2));
      check_eq("ab_restart_state", res_state, 64'h3);
      wait_done("ab_restart_done", 20);

      // Asynchronous reset mid-RUN
      start_batch(8'd2, 10'd50, 8'h05, 1'b0);
      repeat (8) @(negedge clk);
      check_eq("ar_pre_sel", 64'(sel_inhibitor), 64'hFA);
      check_eq("ar_pre_busy", 64'(busy), 64'(1));
      #2 rst = 1'b0;
      #1;
      check_eq("ar_busy", 64'(busy), 64'(0));
      check_eq("ar_dp_rst", 64'(dp_rst), 64'(0));
      check_eq("ar_sel", 64'(sel_inhibitor), 64'hFF);
      check_eq("ar_init", initial_state, 64'(0));
      check_eq("ar_res_valid", 64'(res_valid), 64'(0));
      @(negedge clk);
      rst = 1'b1;
      cnt = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (res_valid || busy || done) cnt++;
      end
      check_eq("ar_quiet", 64'(cnt), 64'(0));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/sim_seed_sequencer.md
# sim_seed_sequencer

Hardware sequencer that drives the SIM_toggle `datapath` through a batch of simulation seeds without a host stepping each control pulse. For each seed it fetches the initial state from a seed memory, resets the datapath, loads the inhibitor selection, pulses `start`, and waits for the iteration limit or an optional steady-state early exit. It then emits one result record per seed over a valid/ready handshake. It sits between the host/config registers and one `datapath` instance.

## Interface
- `STATE`, 64: network state width; must match datapath `STATE`.
- `LOG_RULES`, 8: inhibitor select width.
- `SEED_AW`, 8: seed memory address width; max batch 2^SEED_AW − 1 seeds.
- `ITER_W`, 10: iteration counter width; must match datapath `iteration_number`.

- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `go`  in  1  start a batch; sampled only in IDLE.
- `abort`  in  1  synchronous abort to IDLE from any state.
- `num_seeds`  in  SEED_AW  seed count, latched on `go`.
- `max_iter`  in  ITER_W  iteration limit, latched on `go`.
- `inhibitor`  in  LOG_RULES  inhibitor mask, latched on `go`.
- `early_stop`  in  1  end a seed on `steady_state`, latched on `go`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the batch completes.
- `seed_rd`  out  1  seed memory read strobe.
- `seed_addr`  out  SEED_AW  seed index being read.
- `seed_data`  in  STATE  seed word, valid one cycle after `seed_rd`.
- `dp_rst`  out  1  active-low datapath reset.
- `start`  out  1  datapath start pulse.
- `ld_inhibitor`  out  1  datapath inhibitor load pulse.
- `sel_inhibitor`  out  LOG_RULES  equals ~latched inhibitor.
- `initial_state`  out  STATE  registered seed to the datapath.
- `iteration_number`  in  ITER_W  from the datapath.
- `steady_state`  in  1  from the datapath.
- `network_state`  in  STATE  from the datapath.
- `res_valid`  out  1  result record valid.
- `res_ready`  in  1  consumer accept.
- `res_seed`  out  SEED_AW  seed index of the record.
- `res_state`  out  STATE  `network_state` captured at end of run.
- `res_iters`  out  ITER_W  `iteration_number` captured at end of run.
- `res_steady`  out  1  `steady_state` captured at end of run.

## Operation
- States: IDLE, FETCH, LATCH, RST2, LDINH, GAP, START, RUN, REPORT, DONE.
- IDLE: `dp_rst`=0. On `go`, latch the config and clear the seed index. If `num_seeds`=0, go to DONE; otherwise go to FETCH.
- FETCH: `seed_rd`=1, `seed_addr`=index, `dp_rst`=0.
- LATCH: `initial_state`←`seed_data`, `dp_rst`=0.
- RST2: `dp_rst`=0.
- LDINH: `dp_rst`=1, `ld_inhibitor`=1.
- GAP: one idle cycle.
- START: `start`=1.
- RUN: leave when `iteration_number` ≥ latched `max_iter`, or when `early_stop` && `steady_state`. On leaving, capture the `res_*` fields and go to REPORT.
- REPORT: hold `res_valid`=1 and stable fields until `res_ready`. On the accept cycle, increment the index. If the new index equals `num_seeds`, go to DONE; otherwise go to FETCH.
- DONE: `done`=1 for one cycle, then IDLE.
- `abort`: next state is IDLE from any state. `res_valid` drops and `dp_rst` returns to 0; the partial result is discarded and `done` is not pulsed.
- `go` while busy is ignored. Config changes while busy have no effect.
- Index arithmetic is unsigned SEED_AW bits. The comparison is against the latched count, so there is no wrap.

## Timing
- Reset values: state IDLE, `dp_rst`=0, `busy`/`done`/`seed_rd`/`start`/`ld_inhibitor`/`res_valid`=0, `seed_addr`=0, `initial_state`=0, latched inhibitor=0 (so `sel_inhibitor` is all ones), all `res_*` fields 0.
- Control outputs are registered (Moore): each is asserted for exactly the cycle its state is occupied.
- `go` high at edge 0 gives FETCH at cycle 1, LATCH 2, RST2 3, LDINH 4, GAP 5, START 6, RUN from cycle 7.
- RUN is evaluated every cycle, including its first cycle. With `max_iter`=0, REPORT follows RUN after one cycle.
- Accept in REPORT at cycle k gives FETCH for the next seed at cycle k+1. Per-seed overhead is 7 cycles plus the RUN length plus the REPORT stall.
- `done` is asserted the cycle after the final accept; `busy` falls the following cycle.
- Async reset mid-batch returns immediately to the reset values; no result is emitted.

## Test plan
- Batch of 3 seeds (memory 0x1, 0x2, 0x3), `max_iter`=5, `res_ready` tied 1: expect 3 records with `res_seed` 0,1,2 in order, each `res_iters`≥5, then one `done` pulse.
- Check exact pulse cycles for seed 0: `seed_rd` at cycle 1; `dp_rst` low at cycles 1–3 and high at 4; `ld_inhibitor` at 4; `start` at 6. With `inhibitor`=0x05, expect `sel_inhibitor`=0xFA.
- `early_stop`=1, `steady_state` asserted at iteration 2, `max_iter`=100: expect the record with `res_steady`=1 and `res_iters`=2.
- `num_seeds`=0: expect `done` one cycle after IDLE→DONE, with `seed_rd`, `start` and `ld_inhibitor` never asserted.
- Hold `res_ready` low for 4 cycles in REPORT: expect `res_*` stable and no FETCH until the cycle after accept.
- Assert `abort` during RUN, then `go` again: expect IDLE next cycle, no `done`, and a fresh batch restarting at `res_seed`=0. Drop `rst` mid-RUN: all outputs return to their reset values asynchronously.
